// File: rtl/prom_fetch_bridge.sv
// Fetch bridge: CPU fetch valid/ready <-> Gowin pROM ce/ad/dout; optional fault check via PROM_FETCH_ERR_EN.
// Latency: response valid the cycle after accept (FIFO empty); 1 word/cycle streaming.
// Backpressure: rsp_ready low parks words in a 2-entry FIFO; req_ready drops once FIFO + in-flight hold 2.

module prom_fetch_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 2,
  parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_vld,
  input  logic [W-1:0]  push_dat,
  input  logic          pop_rdy,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head_dat
);
  // DEPTH must be a power of two so the pointers wrap naturally.
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push_vld) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + PW'(1);
      if (pop_rdy)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push_vld) - CW'(pop_rdy);
    end
  end

  assign head_dat = mem[rd_ptr];
endmodule

module prom_fetch_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          AW        = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   req_addr,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_data,
  output logic          rsp_err,
  output logic          rom_ce,
  output logic          rom_oce,
  output logic          rom_reset,
  output logic [AW-1:0] rom_ad,
  input  logic [31:0]   rom_dout
);
  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } rsp_t;

  logic       acc;
  logic       in_range;
  logic       inflight;
  logic       inflight_err;
  logic [1:0] fifo_count;
  logic       from_fifo;
  logic       fifo_push;
  logic       fifo_pop;
  rsp_t       fifo_head;
  rsp_t       ft;
  rsp_t       rsp_cur;

`ifdef PROM_FETCH_ERR_EN
  logic [31:0] addr_off;
  // Addresses below BASE_ADDR wrap to huge offsets and fall out of range.
  assign addr_off = req_addr - BASE_ADDR;
  assign in_range = (addr_off[31:AW+2] == '0) && (req_addr[1:0] == 2'b00);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0], BASE_ADDR};
  assign in_range = 1'b1;
`endif

  // Credit: FIFO occupancy plus the word still coming out of the ROM.
  assign req_ready = ({1'b0, fifo_count} + {2'b00, inflight}) < 3'd2;
  assign acc       = req_valid & req_ready;
  assign rom_ce    = acc & in_range & ~reset;
  assign rom_oce   = 1'b1;
  assign rom_reset = reset;
  assign rom_ad    = req_addr[AW+1:2];

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight     <= 1'b0;
      inflight_err <= 1'b0;
    end else begin
      inflight     <= acc;
      inflight_err <= acc & ~in_range;
    end
  end

  always_comb begin
    ft      = '0;
    ft.err  = inflight_err;
    ft.data = inflight_err ? 32'h0 : rom_dout;
  end

  assign from_fifo = (fifo_count != 2'd0);
  assign rsp_valid = inflight | from_fifo;
  assign rsp_cur   = from_fifo ? fifo_head : ft;

  // The ROM word lives one cycle only; park it unless it leaves right now.
  assign fifo_push = inflight & ~(~from_fifo & rsp_ready);
  assign fifo_pop  = from_fifo & rsp_ready;

  assign rsp_data = (rsp_valid && !rsp_cur.err) ? rsp_cur.data : 32'h0;
`ifdef PROM_FETCH_ERR_EN
  assign rsp_err  = rsp_valid & rsp_cur.err;
`else
  assign rsp_err  = 1'b0;
`endif

  prom_fetch_fifo #(
    .W    ($bits(rsp_t)),
    .DEPTH(2)
  ) u_rsp_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_vld(fifo_push),
    .push_dat(ft),
    .pop_rdy (fifo_pop),
    .count   (fifo_count),
    .head_dat(fifo_head)
  );
endmodule
